imem_loader: RTL and testbench
==============================

# imem_loader

Write-side companion to the combinational instruction-memory read port. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into a 32-entry instruction store starting at a programmable word index. Exposes the same combinational fetch-read interface to the core: 64-bit address in, 32-bit word out, `32'hFFFFFFFF` when out of range. Stalls fetch while a load is in progress.

## Interface
- `DEPTH`, default 32: number of 32-bit instruction words; power of two.
- `ADDR_W`, default `$clog2(DEPTH)` (5): word-index width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `load_start` in 1: single-cycle request to begin a load. Sampled only in IDLE.
- `load_base` in ADDR_W: first word index to write.
- `load_count` in ADDR_W+1: number of words, legal range 1..DEPTH.
- `wr_valid` in 1: the `wr_data` word is valid.
- `wr_ready` out 1: the loader accepts a word this cycle.
- `wr_data` in 32: instruction word.
- `load_busy` out 1: a load is in progress.
- `fetch_stall` out 1: equal to `load_busy`.
- `load_done` out 1: one-cycle pulse when a load completes.
- `load_err` out 1: sticky flag for a rejected request.
- `rd_addr` in 64: fetch word index.
- `rd_data` out 32: instruction word, combinational.

## Operation
- **States:** IDLE, LOAD, DONE.
- **IDLE:**
  - `wr_ready`=0.
  - On `load_start`, the request is legal when `load_count` is in 1..DEPTH and `load_base`+`load_count` ≤ DEPTH. The sum is computed at ADDR_W+2 bits, so no wrap.
  - Legal request: ptr←`load_base`, remaining←`load_count`, `load_err`←0, go to LOAD.
  - Illegal request: `load_err`←1, stay in IDLE, memory untouched.
- **LOAD:**
  - `wr_ready`=1, `load_busy`=1.
  - Each handshake (`wr_valid`&&`wr_ready`) writes mem[ptr]←`wr_data`, then ptr+1 and remaining−1.
  - The handshake that consumes the last word (remaining==1) moves the FSM to DONE.
  - `load_start` is ignored in LOAD.
  - ptr never wraps, because legality was checked at start.
- **DONE:** `load_done`=1 for exactly one cycle, `wr_ready`=0, `load_busy`=0, then IDLE.
- **Read path:**
  - `rd_addr` > DEPTH−1 returns `32'hFFFFFFFF`.
  - Otherwise `rd_data` = mem[`rd_addr[ADDR_W-1:0]`].
  - The read path is purely combinational and available in every state.
- **Read/write same entry in one cycle:** `rd_data` returns the old value. The write lands at the clock edge.
- **Reset (any state, including mid-load):**
  - State→IDLE.
  - All memory words→0; ptr and remaining→0.
  - `wr_ready`=0, `load_busy`=0, `fetch_stall`=0, `load_done`=0, `load_err`=0.
  - A load interrupted by reset is abandoned. Words already written are cleared.

## Timing
- `load_start` in cycle N puts the FSM in LOAD in N+1. `wr_ready` and `load_busy` are high from N+1.
- Throughput: one word per cycle. `wr_valid` gaps stall the load without penalty.
- A word written at edge E is visible on `rd_data` from the cycle after E.
- If the last handshake is in cycle M, `load_done` is high in M+1 and IDLE is reached in M+2. A new `load_start` is accepted from M+2.
- `load_err` rises the cycle after an illegal `load_start`. It holds until reset or the next legal `load_start`.
- `wr_ready` depends only on state (registered decode), never on `wr_valid`.

## Configuration
- **`IMEM_LOAD_CHECKSUM_EN` defined:**
  - Adds output `load_csum` [31:0], the running XOR of all words accepted in the current load.
  - Cleared to 0 on a legal `load_start` and on reset.
  - Final value valid while `load_done`=1 and held until the next legal start.
- **Not defined:** the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- **Package `imem_pkg`:**
  - `IMEM_DEPTH`=32, `IMEM_WORD_W`=32.
  - `IMEM_OOR_DATA`=`32'hFFFFFFFF`.
  - `imem_load_state_t` enum {IDLE, LOAD, DONE}.
- **Sub-module `imem_storage`:**
  - DEPTH×32 register array.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - One combinational read port with the out-of-range check.
  - Synchronous reset clear.
- **`imem_loader`:** holds the FSM, the ptr/remaining counters, the handshake logic and the optional checksum.

## Test plan
- **Basic load:** reset, then `load_start` with base=0, count=3, words `32'h00200793`, `32'h007302B3`, `32'h00000013` with `wr_valid` held high. Required: `load_done` pulses 4 cycles after start, rd_addr 0/1/2 return those words, rd_addr 3 returns 0.
- **Offset load with stalls:** base=29, count=3, `wr_valid` toggling 1,0,1,0,1. Required: exactly 3 writes into entries 29–31, `fetch_stall` high throughout LOAD, `load_done` once.
- **Illegal requests:** count=0, then base=30 with count=3. Required: `load_err`=1 and IDLE kept in both cases, memory unchanged. A following legal start clears `load_err`.
- **Out-of-range read:** rd_addr=32 and rd_addr=`64'hFFFF_FFFF_FFFF_FFFF`. Required: `rd_data`=`32'hFFFFFFFF` in any state.
- **Reset mid-load:** assert `reset` after 2 of 5 words. Required: next cycle all outputs 0, `wr_ready`=0, entries previously written read 0.
- **Checksum (`IMEM_LOAD_CHECKSUM_EN`):** load `32'hA5A5A5A5` then `32'h0F0F0F0F`. Required: `load_csum`=`32'hAAAAAAAA` during `load_done`.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and the loader state type for the instruction-memory write-side loader.
package imem_pkg;

  localparam int IMEM_DEPTH  = 32;
  localparam int IMEM_WORD_W = 32;

  // Value the fetch port returns for any word index past the end of the store
  localparam logic [IMEM_WORD_W-1:0] IMEM_OOR_DATA = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } imem_load_state_t;

endpackage

// File: rtl/imem_storage.sv
// DEPTH x 32 instruction store: one synchronous write port, one combinational
// fetch read port with an out-of-range check, and a synchronous clear on reset.
module imem_storage
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [IMEM_WORD_W-1:0] wdata,
  input  logic [63:0]            rd_addr,
  output logic [IMEM_WORD_W-1:0] rd_data
);

  logic [IMEM_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The full 64-bit index is compared, so any set upper bit reads as out of range
  always_comb begin
    rd_data = IMEM_OOR_DATA;
    if (rd_addr < 64'(DEPTH)) begin
      rd_data = mem[rd_addr[ADDR_W-1:0]];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the instruction store over valid/ready
// and stalls fetch while loading. Define IMEM_LOAD_CHECKSUM_EN to add the load_csum output.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic [ADDR_W-1:0]      load_base,
  input  logic [ADDR_W:0]        load_count,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [IMEM_WORD_W-1:0] wr_data,
  output logic                   load_busy,
  output logic                   fetch_stall,
  output logic                   load_done,
  output logic                   load_err,
  input  logic [63:0]            rd_addr,
  output logic [IMEM_WORD_W-1:0] rd_data
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [IMEM_WORD_W-1:0] load_csum
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_SUM = (ADDR_W+2)'(DEPTH);

  imem_load_state_t  state;
  imem_load_state_t  state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W+1:0] base_plus_count;
  logic              start_legal;
  logic              start_accept;
  logic              handshake;
  logic              last_word;

  // Two extra bits on the sum keep base+count from wrapping past DEPTH
  assign base_plus_count = {2'b00, load_base} + {1'b0, load_count};
  assign start_legal     = (load_count != '0) && (load_count <= DEPTH_CNT) &&
                           (base_plus_count <= DEPTH_SUM);
  assign start_accept    = (state == IDLE) && load_start;
  assign handshake       = (state == LOAD) && wr_valid;
  assign last_word       = (remaining == (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start_accept && start_legal) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        wr_ready  = 1'b1;
        load_busy = 1'b1;
        if (handshake && last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fetch_stall = load_busy;

  // ptr holds on the final word so it never steps past the last legal entry
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      load_err  <= 1'b0;
    end else if (start_accept) begin
      if (start_legal) begin
        ptr       <= load_base;
        remaining <= load_count;
        load_err  <= 1'b0;
      end else begin
        load_err  <= 1'b1;
      end
    end else if (handshake) begin
      remaining <= remaining - (ADDR_W+1)'(1);
      if (!last_word) begin
        ptr <= ptr + ADDR_W'(1);
      end
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      load_csum <= '0;
    end else if (start_accept && start_legal) begin
      load_csum <= '0;
    end else if (handshake) begin
      load_csum <= load_csum ^ wr_data;
    end
  end
`endif

  imem_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk     (clk),
    .reset   (reset),
    .we      (handshake),
    .waddr   (ptr),
    .wdata   (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; the checksum scenario is built
// only when IMEM_LOAD_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [4:0]  load_base;
  logic [5:0]  load_count;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        load_busy;
  logic        fetch_stall;
  logic        load_done;
  logic        load_err;
  logic [63:0] rd_addr;
  logic [31:0] rd_data;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] load_csum;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] basic_words [3] = '{32'h00200793, 32'h007302B3, 32'h00000013};
  logic [31:0] off_words   [3] = '{32'h11110001, 32'h22220002, 32'h33330003};

  always #5 clk = ~clk;

  imem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_count  (load_count),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .load_busy   (load_busy),
    .fetch_stall (fetch_stall),
    .load_done   (load_done),
    .load_err    (load_err),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    .load_csum   (load_csum)
`endif
  );

  // Advance to just after the next rising edge so outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rd_addr = 64'd0;
    #1;
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    tests_run++; if (load_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", load_busy); end
    tests_run++; if (fetch_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", fetch_stall); end
    tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", load_done); end
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", load_err); end
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mem0: got %h expected 00000000", rd_data); end
  endtask

  task automatic test_basic_load();
    load_base = 5'd0; load_count = 6'd3; load_start = 1'b1;
    wr_valid = 1'b1; wr_data = basic_words[0]; rd_addr = 64'd0;
    tick();
    load_start = 1'b0;
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_wr_ready: got %b expected 1", wr_ready); end
    tests_run++; if (load_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy: got %b expected 1", load_busy); end
    tests_run++; if (fetch_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_stall: got %b expected 1", fetch_stall); end
    #1;
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL basic_same_cycle_old: got %h expected 00000000", rd_data); end
    tick();
    wr_data = basic_words[1];
    #1;
    tests_run++; if (rd_data !== basic_words[0]) begin tests_failed++; $display("[TB] FAIL basic_visible_next: got %h expected %h", rd_data, basic_words[0]); end
    tick();
    wr_data = basic_words[2];
    tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_done_early: got %b expected 0", load_done); end
    tick();
    wr_valid = 1'b0;
    tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_done_pulse: got %b expected 1", load_done); end
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_done_ready: got %b expected 0", wr_ready); end
    tests_run++; if (load_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_done_busy: got %b expected 0", load_busy); end
    tick();
    tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_done_width: got %b expected 0", load_done); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 64'(i);
      #1;
      tests_run++; if (rd_data !== basic_words[i]) begin tests_failed++; $display("[TB] FAIL basic_read%0d: got %h expected %h", i, rd_data, basic_words[i]); end
      tick();
    end
    rd_addr = 64'd3;
    #1;
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL basic_read3: got %h expected 00000000", rd_data); end
  endtask

  task automatic test_offset_stall();
    logic [4:0] pat;
    int k;
    pat = 5'b10101;
    k = 0;
    load_base = 5'd29; load_count = 6'd3; load_start = 1'b1; wr_valid = 1'b0;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = pat[i];
      wr_data  = pat[i] ? off_words[k] : 32'hDEADBEEF;
      if (pat[i]) k++;
      tests_run++; if (fetch_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL offset_stall%0d: got %b expected 1", i, fetch_stall); end
      tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL offset_done_early%0d: got %b expected 0", i, load_done); end
      tick();
    end
    wr_valid = 1'b0;
    tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL offset_done: got %b expected 1", load_done); end
    tests_run++; if (fetch_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL offset_stall_done: got %b expected 0", fetch_stall); end
    tick();
    tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL offset_done_once: got %b expected 0", load_done); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 64'(29 + i);
      #1;
      tests_run++; if (rd_data !== off_words[i]) begin tests_failed++; $display("[TB] FAIL offset_read%0d: got %h expected %h", 29 + i, rd_data, off_words[i]); end
      tick();
    end
    rd_addr = 64'd28;
    #1;
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL offset_read28: got %h expected 00000000", rd_data); end
  endtask

  task automatic test_illegal();
    load_base = 5'd0; load_count = 6'd0; load_start = 1'b1; wr_valid = 1'b0;
    tick();
    load_start = 1'b0;
    tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_count0_err: got %b expected 1", load_err); end
    tests_run++; if (load_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_count0_busy: got %b expected 0", load_busy); end
    tick();
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_count0_idle: got %b expected 0", wr_ready); end
    load_base = 5'd30; load_count = 6'd3; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_overrun_err: got %b expected 1", load_err); end
    tests_run++; if (load_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_overrun_busy: got %b expected 0", load_busy); end
    rd_addr = 64'd30;
    #1;
    tests_run++; if (rd_data !== off_words[1]) begin tests_failed++; $display("[TB] FAIL illegal_mem30: got %h expected %h", rd_data, off_words[1]); end
    rd_addr = 64'd0;
    #1;
    tests_run++; if (rd_data !== basic_words[0]) begin tests_failed++; $display("[TB] FAIL illegal_mem0: got %h expected %h", rd_data, basic_words[0]); end
    tick();
    load_base = 5'd5; load_count = 6'd1; load_start = 1'b1; wr_valid = 1'b1; wr_data = 32'hCAFE0005;
    tick();
    load_start = 1'b0;
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_cleared: got %b expected 0", load_err); end
    tests_run++; if (load_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL legal_busy: got %b expected 1", load_busy); end
    tick();
    wr_valid = 1'b0;
    tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL legal_single_done: got %b expected 1", load_done); end
    tick();
    load_base = 5'd0; load_count = 6'd33; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_count33_err: got %b expected 1", load_err); end
    load_base = 5'd31; load_count = 6'd1; load_start = 1'b1; wr_valid = 1'b1; wr_data = 32'h31313131;
    tick();
    load_start = 1'b0;
    tests_run++; if (load_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL edge_base31_busy: got %b expected 1", load_busy); end
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL edge_base31_err: got %b expected 0", load_err); end
    tick();
    wr_valid = 1'b0;
    tick();
    rd_addr = 64'd5;
    #1;
    tests_run++; if (rd_data !== 32'hCAFE0005) begin tests_failed++; $display("[TB] FAIL legal_read5: got %h expected cafe0005", rd_data); end
    rd_addr = 64'd31;
    #1;
    tests_run++; if (rd_data !== 32'h31313131) begin tests_failed++; $display("[TB] FAIL edge_read31: got %h expected 31313131", rd_data); end
  endtask

  task automatic test_oor_read();
    rd_addr = 64'd32;
    #1;
    tests_run++; if (rd_data !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL oor_32: got %h expected ffffffff", rd_data); end
    rd_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    tests_run++; if (rd_data !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL oor_max: got %h expected ffffffff", rd_data); end
    rd_addr = 64'h1_0000_0001;
    #1;
    tests_run++; if (rd_data !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL oor_upper: got %h expected ffffffff", rd_data); end
    tick();
  endtask

  task automatic test_reset_midload();
    load_base = 5'd10; load_count = 6'd5; load_start = 1'b1; wr_valid = 1'b0;
    tick();
    load_start = 1'b0; wr_valid = 1'b1; wr_data = 32'hAAAA0010;
    tick();
    wr_data = 32'hBBBB0011;
    tick();
    wr_valid = 1'b0;
    rd_addr = 64'd11;
    #1;
    tests_run++; if (rd_data !== 32'hBBBB0011) begin tests_failed++; $display("[TB] FAIL midload_read11: got %h expected bbbb0011", rd_data); end
    rd_addr = 64'd32;
    #1;
    tests_run++; if (rd_data !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL midload_oor: got %h expected ffffffff", rd_data); end
    tests_run++; if (load_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL midload_busy: got %b expected 1", load_busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_ready: got %b expected 0", wr_ready); end
    tests_run++; if (load_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", load_busy); end
    tests_run++; if (fetch_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_stall: got %b expected 0", fetch_stall); end
    tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_done: got %b expected 0", load_done); end
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_err: got %b expected 0", load_err); end
    rd_addr = 64'd10;
    #1;
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_read10: got %h expected 00000000", rd_data); end
    rd_addr = 64'd11;
    #1;
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_read11: got %h expected 00000000", rd_data); end
    rd_addr = 64'd0;
    #1;
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_read0: got %h expected 00000000", rd_data); end
    tick();
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_stays_idle: got %b expected 0", wr_ready); end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    load_base = 5'd0; load_count = 6'd2; load_start = 1'b1; wr_valid = 1'b0;
    tick();
    load_start = 1'b0; wr_valid = 1'b1; wr_data = 32'hA5A5A5A5;
    tick();
    wr_data = 32'h0F0F0F0F;
    tick();
    wr_valid = 1'b0;
    tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL csum_done: got %b expected 1", load_done); end
    tests_run++; if (load_csum !== 32'hAAAAAAAA) begin tests_failed++; $display("[TB] FAIL csum_value: got %h expected aaaaaaaa", load_csum); end
    tick();
    tests_run++; if (load_csum !== 32'hAAAAAAAA) begin tests_failed++; $display("[TB] FAIL csum_hold: got %h expected aaaaaaaa", load_csum); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_base  = '0;
    load_count = '0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    rd_addr    = '0;
    test_reset();
    test_basic_load();
    test_offset_stall();
    test_illegal();
    test_oor_read();
    test_reset_midload();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
